sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
Shares one SRAM-like memory port between the CPU instruction-fetch requester and the data-access requester. Sits between the mips core and the single external memory/bridge port. Holds at most one outstanding transaction. Data requests win by default, and an anti-starvation counter forces an instruction grant after a bounded number of data wins.

Parameters:
STARVE_LIMIT, 4, consecutive IDLE-cycle data grants made while inst_req is pending before inst is forced to win; range 1..15
ADDR_W, 32, address width

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous reset, active-low
inst_req  in  1  fetch request
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
inst_rdata  out  32  fetch data
data_req  in  1  load/store request
data_wr  in  1  1 = store
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  ADDR_W  load/store address
data_wdata  in  32  store data
data_addr_ok  out  1  load/store request accepted
data_data_ok  out  1  load done / store complete
data_rdata  out  32  load data
mem_req  out  1  request to shared port
mem_wr  out  1  write flag
mem_size  out  2  access size
mem_addr  out  ADDR_W  address
mem_wdata  out  32  write data
mem_addr_ok  in  1  slave accepted request
mem_data_ok  in  1  slave response valid
mem_rdata  in  32  slave read data

Behaviour:
- FSM states: IDLE, ADDR, WAIT. Registers: owner (0 = inst, 1 = data), latched wr/size/addr/wdata, starve counter (4 bits).
- IDLE: grant is combinational.
  - inst wins if inst_req && (!data_req || starve == STARVE_LIMIT); otherwise data wins if data_req.
  - Winner's *_addr_ok = 1 in that cycle. The loser sees addr_ok = 0 and must hold its request.
  - On grant: latch fields and owner, go to ADDR.
  - Inst grant forces wr = 0, size = 2, wdata = 0.
- ADDR: mem_req = 1, driven only from latched registers, so it is stable regardless of requester inputs.
  - mem_addr_ok = 1 and mem_data_ok = 0: go to WAIT.
  - mem_addr_ok = 1 and mem_data_ok = 1 in the same cycle: complete now, go to IDLE.
  - Otherwise hold in ADDR.
- WAIT: mem_req = 0. On mem_data_ok, complete and go to IDLE.
- Completion: owner's *_data_ok = mem_data_ok, combinational, in the completing cycle only. *_rdata = mem_rdata, passed through combinationally.
- mem_data_ok outside the legal windows (IDLE, or ADDR without mem_addr_ok) is ignored: no *_data_ok is asserted.
- Starve counter, updated only on IDLE grants:
  - data grant while inst_req = 1: increment, saturating at STARVE_LIMIT.
  - inst grant: clear to 0.
  - data grant with inst_req = 0: clear to 0.
- Latency:
  - accept (cycle 0), mem_req (cycle 1), earliest data_ok (cycle 1) when the slave returns addr_ok and data_ok together.
  - Next accept no earlier than the cycle after completion, so back-to-back throughput is 1 transaction per 2 cycles minimum.
- Reset (resetn low, asynchronous, any state including mid-transaction):
  - state = IDLE, owner = 0, starve = 0, latched fields = 0.
  - mem_req, mem_wr, *_addr_ok and *_data_ok all 0 immediately.
  - An in-flight transaction is dropped; a late mem_data_ok after reset release is ignored per the IDLE rule.
- Outputs when not owner: *_data_ok = 0. *_rdata still mirrors mem_rdata; requesters must qualify it with *_data_ok.
- No combinational path from mem_addr_ok to any requester addr_ok.

Test Plan:
- Inst only: inst_req = 1, addr 0xBFC00000; slave gives addr_ok at cycle 1 and data_ok with 0x24080001 at cycle 3 -> inst_addr_ok at cycle 0; mem_addr = 0xBFC00000, mem_wr = 0, mem_size = 2; inst_data_ok = 1 with rdata 0x24080001 at cycle 3; data_data_ok stays 0.
- Simultaneous requests: inst and data both asserted, data is a store of 0xDEADBEEF to 0x80000010, size 2 -> data_addr_ok cycle 0, inst_addr_ok 0; mem_wr = 1, wdata 0xDEADBEEF; after completion inst is granted in the next IDLE cycle.
- Starvation with STARVE_LIMIT = 4: data_req and inst_req held high continuously, slave zero-wait -> grants D, D, D, D, I, D…; inst is granted on the 5th IDLE grant.
- Slave stall: mem_addr_ok held 0 for 5 cycles while requester inputs change -> mem_req, mem_addr and mem_wdata stay constant at the latched values; no new *_addr_ok.
- Same-cycle completion: in ADDR, mem_addr_ok = 1 and mem_data_ok = 1 -> owner data_ok the same cycle; FSM returns to IDLE and can accept again one cycle later.
- Reset mid-WAIT: resetn low in WAIT, then a stray mem_data_ok after release -> mem_req = 0 at once; no *_data_ok pulse; starve = 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for a single SRAM-like port: inst fetch vs data access,
// one outstanding transaction, data priority with a bounded inst starvation count.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_q, state_d;
  logic       owner_q;
  req_t       req_q, req_d;
  logic [3:0] starve_q, starve_d;
  logic       inst_win, data_win, complete;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    starve_d = starve_q;
    inst_win = inst_req && (!data_req || starve_q == LIMIT);
    data_win = data_req && !inst_win;
    complete = 1'b0;
    case (state_q)
      IDLE: if (inst_win || data_win) begin
        state_d = ADDR;
        req_d   = data_win ? req_t'{data_wr, data_size, data_addr, data_wdata}
                           : req_t'{1'b0, 2'd2, inst_addr, 32'd0};
        // Only data wins over a waiting fetch count toward starvation.
        if (data_win && inst_req)
          starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
        else
          starve_d = 4'd0;
      end
      ADDR: if (mem_addr_ok) begin
        complete = mem_data_ok;
        state_d  = mem_data_ok ? IDLE : WAIT;
      end
      WAIT: if (mem_data_ok) begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      req_q    <= '0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      starve_q <= starve_d;
      if (state_q == IDLE && (inst_win || data_win)) owner_q <= data_win;
    end
  end

  // Grants are gated by resetn so they drop the instant reset asserts.
  assign inst_addr_ok = resetn && state_q == IDLE && inst_win;
  assign data_addr_ok = resetn && state_q == IDLE && data_win;
  assign inst_data_ok = complete && !owner_q;
  assign data_data_ok = complete && owner_q;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign mem_req   = state_q == ADDR;
  assign mem_wr    = req_q.wr;
  assign mem_size  = req_q.size;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
endmodule
